// File: rtl/nested_loop_counter_if.sv
// Control/status bundle for nested_loop_counter.
//   master : drives START, ABORT, ENABLE, BOUNDS; observes the outputs
//   slave  : the counter itself
//   START/ABORT/ENABLE  run control
//   BOUNDS              per-level iteration count, level k at [k*SIZE +: SIZE]
//   VALUES              current per-level index, same packing as BOUNDS
//   WRAP                bit k = level k wrapped on the previous edge
//   BUSY                high while a run is in progress
//   DONE                one-cycle pulse after the final step of the nest
interface nested_loop_counter_if #(
  parameter int SIZE       = 8,
  parameter int NUM_LEVELS = 3
);
  logic                       START;
  logic                       ABORT;
  logic                       ENABLE;
  logic [NUM_LEVELS*SIZE-1:0] BOUNDS;
  logic [NUM_LEVELS*SIZE-1:0] VALUES;
  logic [NUM_LEVELS-1:0]      WRAP;
  logic                       BUSY;
  logic                       DONE;

  modport master (
    output START, ABORT, ENABLE, BOUNDS,
    input  VALUES, WRAP, BUSY, DONE
  );

  modport slave (
    input  START, ABORT, ENABLE, BOUNDS,
    output VALUES, WRAP, BUSY, DONE
  );
endinterface

// File: rtl/nested_loop_counter.sv
// Nested loop counter: NUM_LEVELS chained counters walking a loop nest,
// level 0 innermost, each with a bound latched at START.
//   CLK      rising-edge clock
//   RESET_N  asynchronous active-low reset
//   bus      nested_loop_counter_if.slave (control in, indices/flags out)

// Per-level step logic: next index and wrap flag given the carry from
// the inner levels. Bound is never 0 here (0 is latched as 1).
module nested_loop_counter_level #(
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0] idx_i,
  input  logic [SIZE-1:0] bnd_i,
  input  logic            carry_i,
  output logic            at_max_o,
  output logic [SIZE-1:0] nxt_o,
  output logic            wrap_o
);
  // bound-1 in SIZE bits keeps bound 2^SIZE-1 reachable
  assign at_max_o = (idx_i == (bnd_i - SIZE'(1)));
  assign wrap_o   = carry_i & at_max_o;
  assign nxt_o    = !carry_i ? idx_i : (at_max_o ? '0 : idx_i + SIZE'(1));
endmodule

module nested_loop_counter #(
  parameter int SIZE       = 8,
  parameter int NUM_LEVELS = 3
) (
  input logic                   CLK,
  input logic                   RESET_N,
  nested_loop_counter_if.slave  bus
);
  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                               state_q, state_d;
  logic [NUM_LEVELS-1:0][SIZE-1:0]      idx_q, idx_d;
  logic [NUM_LEVELS-1:0][SIZE-1:0]      bnd_q, bnd_d;
  logic [NUM_LEVELS-1:0]                wrap_q, wrap_d;
  logic                                 done_q, done_d;

  logic [NUM_LEVELS-1:0][SIZE-1:0]      bnd_in;
  logic [NUM_LEVELS-1:0][SIZE-1:0]      step_idx;
  logic [NUM_LEVELS-1:0]                step_wrap;
  logic [NUM_LEVELS-1:0]                at_max;
  logic [NUM_LEVELS:0]                  carry;
  logic                                 all_max;

  assign bnd_in = bus.BOUNDS;

  // Level k advances only when every inner level sits at its max.
  always_comb begin
    carry[0] = 1'b1;
    for (int k = 0; k < NUM_LEVELS; k++)
      carry[k+1] = carry[k] & at_max[k];
  end
  assign all_max = carry[NUM_LEVELS];

  for (genvar k = 0; k < NUM_LEVELS; k++) begin : g_lvl
    nested_loop_counter_level #(.SIZE(SIZE)) u_lvl (
      .idx_i    (idx_q[k]),
      .bnd_i    (bnd_q[k]),
      .carry_i  (carry[k]),
      .at_max_o (at_max[k]),
      .nxt_o    (step_idx[k]),
      .wrap_o   (step_wrap[k])
    );
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    bnd_d   = bnd_q;
    wrap_d  = '0;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          // A zero bound becomes 1 so that level never stalls the nest.
          for (int k = 0; k < NUM_LEVELS; k++)
            bnd_d[k] = (bnd_in[k] == '0) ? SIZE'(1) : bnd_in[k];
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.ABORT) begin
          idx_d   = '0;
          state_d = S_IDLE;
        end else if (bus.ENABLE) begin
          // On the final step every level wraps, so step_idx is all zero.
          idx_d  = step_idx;
          wrap_d = step_wrap;
          if (all_max) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      bnd_q   <= {NUM_LEVELS{SIZE'(1)}};
      wrap_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bnd_q   <= bnd_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign bus.VALUES = idx_q;
  assign bus.WRAP   = wrap_q;
  assign bus.BUSY   = (state_q == S_RUN);
  assign bus.DONE   = done_q;
endmodule

// File: tb/tb_nested_loop_counter.sv
module tb_nested_loop_counter;
  localparam int SZ = 8;
  localparam int NL = 3;
  localparam int EW = NL*SZ + NL + 2;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  always #5 CLK = ~CLK;

  nested_loop_counter_if #(.SIZE(SZ), .NUM_LEVELS(NL)) m_if ();
  nested_loop_counter_if #(.SIZE(4),  .NUM_LEVELS(1))  s_if ();

  nested_loop_counter #(.SIZE(SZ), .NUM_LEVELS(NL)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .bus(m_if.slave)
  );
  nested_loop_counter #(.SIZE(4), .NUM_LEVELS(1)) dut_small (
    .CLK(CLK), .RESET_N(RESET_N), .bus(s_if.slave)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: the nest is a single linear position in a
  // mixed-radix number whose digits are the per-level bounds.
  int       m_b [NL];
  bit       m_run;
  int       m_pos;
  logic [NL-1:0] m_wrap;
  bit       m_done;

  logic [EW-1:0] q [$];

  task automatic model_reset();
    for (int k = 0; k < NL; k++) m_b[k] = 1;
    m_run = 0; m_pos = 0; m_wrap = '0; m_done = 0;
  endtask

  function automatic logic [EW-1:0] model_out();
    logic [NL*SZ-1:0] v;
    int rad;
    rad = 1;
    v = '0;
    for (int k = 0; k < NL; k++) begin
      v[k*SZ +: SZ] = SZ'((m_pos / rad) % m_b[k]);
      rad = rad * m_b[k];
    end
    return {v, m_wrap, m_run, m_done};
  endfunction

  task automatic model_step(input logic st, ab, en, input logic [NL*SZ-1:0] bd);
    int np, rad;
    m_wrap = '0; m_done = 0;
    if (!m_run) begin
      if (st) begin
        for (int k = 0; k < NL; k++) begin
          m_b[k] = int'(bd[k*SZ +: SZ]);
          if (m_b[k] == 0) m_b[k] = 1;
        end
        m_pos = 0; m_run = 1;
      end
    end else if (ab) begin
      m_run = 0; m_pos = 0;
    end else if (en) begin
      np = m_pos + 1; rad = 1;
      for (int k = 0; k < NL; k++) begin
        rad = rad * m_b[k];
        m_wrap[k] = (np % rad == 0);
      end
      if (np == rad) begin
        m_done = 1; m_run = 0; m_pos = 0;
      end else m_pos = np;
    end
  endtask

  // One stimulus cycle: drive, predict, enqueue expectation.
  task automatic cyc(input logic st, ab, en, input logic [NL*SZ-1:0] bd);
    @(negedge CLK);
    m_if.START = st; m_if.ABORT = ab; m_if.ENABLE = en; m_if.BOUNDS = bd;
    model_step(st, ab, en, bd);
    q.push_back(model_out());
  endtask

  // Monitor: compare every registered update against the queue.
  always begin
    logic [EW-1:0] e, g;
    @(posedge CLK);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      g = {m_if.VALUES, m_if.WRAP, m_if.BUSY, m_if.DONE};
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL sb t=%0t got vals=%h wrap=%b busy=%b done=%b exp vals=%h wrap=%b busy=%b done=%b",
                 $time, g[EW-1 -: NL*SZ], g[NL+1:2], g[1], g[0],
                 e[EW-1 -: NL*SZ], e[NL+1:2], e[1], e[0]);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  localparam logic [NL*SZ-1:0] B432 = {8'd4, 8'd3, 8'd2};

  initial begin
    m_if.START = 0; m_if.ABORT = 0; m_if.ENABLE = 1; m_if.BOUNDS = '0;
    s_if.START = 0; s_if.ABORT = 0; s_if.ENABLE = 0; s_if.BOUNDS = '0;
    model_reset();

    // Reset held with ENABLE high.
    #22;
    chk("rst_vals", 32'(m_if.VALUES), 0);
    chk("rst_busy", 32'(m_if.BUSY), 0);
    chk("rst_done", 32'(m_if.DONE), 0);
    chk("rst_wrap", 32'(m_if.WRAP), 0);
    @(negedge CLK);
    RESET_N = 1;
    repeat (5) cyc(0, 0, 1, '0);

    // Full nest, ENABLE held.
    cyc(1, 0, 0, B432);
    repeat (24) cyc(0, 0, 1, B432);
    cyc(0, 0, 1, B432);

    // Gapped enable.
    cyc(1, 0, 0, B432);
    for (int i = 0; i < 48; i++) cyc(0, 0, (i % 2) == 0, B432);
    cyc(0, 0, 0, B432);

    // Boundary bounds: 0 / 255 / 1.
    cyc(1, 0, 0, {8'd1, 8'd255, 8'd0});
    repeat (256) cyc(0, 0, 1, '0);

    // START during RUN ignored; ABORT+ENABLE at (1,2,0); START+ENABLE in IDLE.
    cyc(1, 0, 0, B432);
    repeat (4) cyc(0, 0, 1, B432);
    cyc(1, 0, 0, {8'd1, 8'd1, 8'd1});
    repeat (6) cyc(0, 0, 1, {8'd1, 8'd1, 8'd1});
    cyc(0, 1, 1, B432);
    cyc(0, 0, 0, B432);
    cyc(1, 0, 1, B432);
    repeat (24) cyc(0, 0, 1, B432);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [NL*SZ-1:0] bd;
      for (int k = 0; k < NL; k++) bd[k*SZ +: SZ] = SZ'($urandom_range(0, 5));
      cyc(($urandom % 6) == 0, ($urandom % 80) == 0, ($urandom % 4) != 0, bd);
    end
    cyc(0, 1, 0, '0);
    cyc(0, 0, 0, '0);

    // SIZE=4, bound 15: reaches 14, wraps, DONE on step 15.
    @(posedge CLK); #2;
    @(negedge CLK);
    s_if.START = 1; s_if.BOUNDS = 4'd15;
    @(negedge CLK);
    s_if.START = 0; s_if.ENABLE = 1;
    chk("small_start", 32'(s_if.VALUES), 0);
    for (int i = 0; i < 15; i++) begin
      @(posedge CLK); #1;
      chk("small_vals", 32'(s_if.VALUES), 32'((i + 1) % 15));
      chk("small_done", 32'(s_if.DONE), 32'(i == 14));
    end
    @(negedge CLK);
    s_if.ENABLE = 0;

    // Async reset mid-run at (2,1,1).
    cyc(1, 0, 0, B432);
    repeat (15) cyc(0, 0, 1, B432);
    @(posedge CLK); #2;
    chk("pre_rst", 32'(m_if.VALUES), 32'({8'd2, 8'd1, 8'd1}));
    m_if.ENABLE = 0;
    RESET_N = 0;
    #1;
    chk("arst_vals", 32'(m_if.VALUES), 0);
    chk("arst_busy", 32'(m_if.BUSY), 0);
    model_reset();
    @(negedge CLK);
    RESET_N = 1;
    cyc(1, 0, 0, {8'd3, 8'd2, 8'd5});
    repeat (31) cyc(0, 0, 1, '0);

    @(posedge CLK); #3;
    chk("drain", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/nested_loop_counter.md
Name: nested_loop_counter

Overview:
- Parametrised successor to the single-level counter: a chain of NUM_LEVELS counters that walks a nested loop space.
- Level 0 is the innermost loop; each level has its own runtime bound.
- Drives the loop indices (e.g. output row/col/channel) for layer sequencing in the inference datapath.
- Start/run/done control plus per-level wrap flags, so downstream logic can trigger accumulate/flush events without re-decoding the indices.

Parameters:
- SIZE, 8, width of each level's index and bound.
- NUM_LEVELS, 3, number of nested levels (>= 1); level 0 is innermost.

Ports:
- CLK  input  1  clock; all state is updated on the rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- START  input  1  in IDLE: latch BOUNDS, clear indices, enter RUN.
- ABORT  input  1  in RUN: return to IDLE and clear indices; no DONE.
- ENABLE  input  1  in RUN: advance the loop nest by one step.
- BOUNDS  input  NUM_LEVELS*SIZE  per-level iteration count; level k occupies bits [k*SIZE +: SIZE].
- VALUES  output  NUM_LEVELS*SIZE  current index per level, same packing as BOUNDS.
- WRAP  output  NUM_LEVELS  bit k = level k wrapped on the previous edge.
- BUSY  output  1  high while in RUN.
- DONE  output  1  one-cycle pulse after the final step of the nest.

Behaviour:
- Reset (async assert, sync release): state IDLE; VALUES=0, WRAP=0, BUSY=0, DONE=0; latched bounds=1.
- FSM, IDLE:
  - START=1 -> latch BOUNDS, set VALUES=0, enter RUN.
  - ENABLE and ABORT are ignored in IDLE.
  - START and ENABLE in the same cycle -> START only; no step is taken.
- FSM, RUN:
  - START is ignored; the latched bounds stay frozen for the whole run.
  - ABORT=1 -> IDLE, VALUES=0, WRAP=0, DONE=0. ABORT wins over ENABLE in the same cycle.
  - ENABLE=1 and not all levels at max -> step. No state change.
  - ENABLE=1 and every level k at latched_bound[k]-1 -> all levels go to 0, WRAP all ones for one cycle, DONE=1 for one cycle, enter IDLE.
- Step rule:
  - Level 0 always increments.
  - Level k increments only if every level j<k is at latched_bound[j]-1.
  - A level that increments while at bound-1 goes to 0 and sets its WRAP bit; otherwise it goes to index+1.
  - All levels update on the same edge; there is no ripple latency.
- Bound of 0 is latched as 1, so that level is always at max and never stalls the nest.
- Latency: VALUES, WRAP and DONE are registered and reflect the step one cycle after the ENABLE edge.
- WRAP and DONE are single-cycle pulses. They clear on the next edge unless the same event repeats.
- ENABLE=0 in RUN -> hold all VALUES; WRAP clears to 0.
- Arithmetic: compare against bound-1 in SIZE bits, so bound 2^SIZE-1 is reachable. An index never equals or exceeds its bound.
- BUSY=1 exactly while in RUN. BUSY drops on the same edge on which DONE rises.
- RESET_N asserted mid-run -> immediate return to reset values, regardless of CLK.
- Total steps per run = product of the latched bounds (each bound of 0 counted as 1).

Test Plan:
- Reset then idle: RESET_N=0 with ENABLE=1 held -> VALUES=0, BUSY=0, DONE=0. Release reset, pulse ENABLE 5 cycles with no START -> VALUES stays 0.
- Full nest: NUM_LEVELS=3, SIZE=8, BOUNDS={4,3,2} (level2,1,0), START, then ENABLE held.
  - Expected VALUES sequence (l2,l1,l0): (0,0,0),(0,0,1),(0,1,0),...,(3,2,1).
  - WRAP[0] pulses every 2 steps and WRAP[1] every 6 steps.
  - On step 24: all levels go to 0, WRAP=3'b111, DONE pulses once, BUSY falls.
- Gapped enable: same bounds with ENABLE toggling 1,0,1,0 -> VALUES advance only on enabled cycles, WRAP=0 in hold cycles, DONE after 24 enabled cycles.
- Boundary bounds:
  - BOUNDS level0=0, level1=255, level2=1 -> level0 stuck at 0 and level1 counts 0..254; DONE after 255 steps.
  - SIZE=4 with bound 15 -> index reaches 14 then wraps.
- Control corners:
  - START during RUN -> ignored; bounds unchanged.
  - ABORT+ENABLE same cycle at (1,2,0) -> IDLE, VALUES=0, no DONE.
  - START+ENABLE in IDLE -> VALUES=0 the next cycle.
- Async reset mid-run: at VALUES=(2,1,1) drive RESET_N low between edges -> outputs 0 immediately. After release, a new START with new BOUNDS runs correctly from (0,0,0).
